// File: rtl/uart_rx_engine.sv
// UART receive de-framer: synchronises rx, samples start/data/parity/stop bits mid-bit, latches byte + error flags.
// Latency: byte and flags are registered on the stop-bit sample edge (visible 1 clk after the stop sample decision).
// No backpressure: a new byte overwrites an unread one and raises ovf; clear drops rx_rdy and the flags.
module uart_rx_engine #(
  parameter int K_W    = 19,
  parameter int SYNC_N = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic           eight,
  input  logic           pen,
  input  logic           even,
  input  logic           clear,
  input  logic [K_W-1:0] k,
  output logic           rx_rdy,
  output logic [7:0]     data,
  output logic           perr,
  output logic           ferr,
  output logic           ovf
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [SYNC_N-1:0] sync_q;
  logic              rxs;
  logic [2:0]        state_q, state_d;
  logic [K_W-1:0]    cnt_q, cnt_d;
  logic [K_W-1:0]    term_q, term_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              eight_q, eight_d;
  logic              pen_q, pen_d;
  logic              even_q, even_d;
  logic              rdy_q, rdy_d;
  logic [7:0]        data_q, data_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  logic [K_W-1:0]    k_eff;
  logic              tick;
  logic              done;
  logic [7:0]        byte_v;
  logic              perr_v;

  assign rxs = sync_q[SYNC_N-1];

  // Bit timing, frame FSM and completion/clear handling of the output registers.
  always_comb begin
    k_eff    = (k < K_W'(2)) ? K_W'(2) : k;
    tick     = (cnt_q == term_q);
    state_d  = state_q;
    cnt_d    = cnt_q + K_W'(1);
    term_d   = term_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    eight_d  = eight_q;
    pen_d    = pen_q;
    even_d   = even_q;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (!rxs) begin
          // Half a bit time lands the start sample mid-bit.
          state_d = ST_START;
          cnt_d   = K_W'(1);
          term_d  = k_eff >> 1;
          eight_d = eight;
          pen_d   = pen;
          even_d  = even;
        end
      end
      ST_START: begin
        if (tick) begin
          cnt_d  = K_W'(1);
          term_d = k_eff;
          bit_d  = 3'd0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d   = K_W'(1);
          term_d  = k_eff;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == (eight_q ? 3'd7 : 3'd6)) begin
            state_d = pen_q ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          cnt_d   = K_W'(1);
          term_d  = k_eff;
          par_d   = rxs;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // In 7-bit mode the byte sits in the upper seven shift bits.
    byte_v = eight_q ? shift_q : {1'b0, shift_q[7:1]};
    perr_v = pen_q & (^byte_v ^ par_q ^ ~even_q);

    rdy_d  = rdy_q;
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovf_d  = ovf_q;
    if (done) begin
      rdy_d  = 1'b1;
      data_d = byte_v;
      perr_d = perr_v;
      ferr_d = ~rxs;
      ovf_d  = rdy_q & ~clear;
    end else if (clear) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  // Synchroniser chain for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_N-2:0], rx};
  end

  // Frame state, timer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      term_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      even_q  <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      eight_q <= eight_d;
      pen_q   <= pen_d;
      even_q  <= even_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rx_rdy = rdy_q;
  assign data   = data_q;
  assign perr   = perr_q;
  assign ferr   = ferr_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frames are driven bit-serially with hand-computed expectations.
// Timing: rx changes 1ns after a rising edge; outputs are sampled 1ns after a rising edge.
// Clear pulses are one cycle wide; one test aligns clear with the predicted stop-sample edge.
module tb_uart_rx_engine;
  localparam int KW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          eight;
  logic          pen;
  logic          even;
  logic          clear;
  logic [KW-1:0] k;
  logic          rx_rdy;
  logic [7:0]    data;
  logic          perr;
  logic          ferr;
  logic          ovf;

  int bit_cyc = 16;
  int n_chk   = 0;
  int n_pass  = 0;

  uart_rx_engine #(.K_W(KW), .SYNC_N(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .eight (eight),
    .pen   (pen),
    .even  (even),
    .clear (clear),
    .k     (k),
    .rx_rdy(rx_rdy),
    .data  (data),
    .perr  (perr),
    .ferr  (ferr),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Start bit, LSB-first data, optional parity, stop; each bit lasts bit_cyc clocks.
  task automatic send_frame(input logic [7:0] b, input logic e8, input logic p_en,
                            input logic p_bit, input logic stop_bit);
    logic [11:0] bits;
    int n;
    bits = '0;
    n = 0;
    eight = e8;
    pen = p_en;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < (e8 ? 8 : 7); i++) begin
      bits[n] = b[i];
      n++;
    end
    if (p_en) begin
      bits[n] = p_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (bit_cyc) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic rdy_e, input logic [7:0] data_e,
                         input logic perr_e, input logic ferr_e, input logic ovf_e);
    chk_eq({tag, ".rx_rdy"}, {31'd0, rx_rdy}, {31'd0, rdy_e});
    chk_eq({tag, ".data"},   {24'd0, data},   {24'd0, data_e});
    chk_eq({tag, ".perr"},   {31'd0, perr},   {31'd0, perr_e});
    chk_eq({tag, ".ferr"},   {31'd0, ferr},   {31'd0, ferr_e});
    chk_eq({tag, ".ovf"},    {31'd0, ovf},    {31'd0, ovf_e});
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; eight = 1'b1; pen = 1'b0; even = 1'b0; clear = 1'b0;
    k = KW'(16);
    #1;
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);

    // 8N1 0xA5; stop sample lands on edge 155 after the start-bit edge (3 sync/detect + 8 + 9*16).
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 chk_eq("lat_before", {31'd0, rx_rdy}, 32'd0);
        @(posedge clk);
        #1 chk_eq("lat_after", {31'd0, rx_rdy}, 32'd1);
      end
    join
    wait_cyc(2);
    chk_out("8n1_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // 7E1 0x41: two ones, even parity bit 0 is correct, 1 is wrong.
    even = 1'b1;
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_cyc(2);
    chk_out("7e1_ok", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_cyc(2);
    chk_out("7e1_bad", 1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    even = 1'b0;

    // 8N1 with stop bit low: byte still latched, ferr set; clear drops flags, data holds.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cyc(2);
    chk_out("ferr", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    wait_cyc(30);
    pulse_clear();
    wait_cyc(1);
    chk_out("ferr_clr", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Back-to-back without clear: overwrite and overflow.
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cyc(2);
    chk_out("ovf", 1'b1, 8'h34, 1'b0, 1'b0, 1'b1);
    pulse_clear();
    wait_cyc(1);
    chk_out("ovf_clr", 1'b0, 8'h34, 1'b0, 1'b0, 1'b0);

    // Back-to-back with clear on the second completion edge: completion wins, no overflow.
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    fork
      send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
      end
    join
    wait_cyc(2);
    chk_out("clr_coinc", 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // Start glitch of k/4 clocks: false start, nothing latched; then a good 0x5A.
    @(posedge clk);
    #1 rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(30);
    chk_eq("glitch.rx_rdy", {31'd0, rx_rdy}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cyc(2);
    chk_out("after_glitch", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    // k below 2 behaves as k=2: 8N1 0xC3 with 2-clock bits.
    pulse_clear();
    k = KW'(1);
    bit_cyc = 2;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cyc(4);
    chk_out("k_min", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    k = KW'(16);
    bit_cyc = 16;
    wait_cyc(10);

    // Reset in the middle of a data bit: outputs drop at once (rx_rdy was 1).
    @(posedge clk);
    #1 rx = 1'b0;
    wait_cyc(16);
    rx = 1'b1;
    wait_cyc(24);
    rst = 1'b0;
    #2;
    chk_out("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);

    // 8O1 0xFF: eight ones, odd parity bit is 1.
    even = 1'b0;
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_cyc(2);
    chk_out("8o1_ff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
